command_decoder: RTL and testbench
==================================

COMMAND_DECODER -- requirements
Module: command_decoder

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 24'd1000000, inter-byte timeout in clk cycles for multi-byte commands.
REQ-002 SHALL provide port clk  input  1  system clock; all state changes on posedge clk.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port rx_data  input  8  command byte from host link.
REQ-005 SHALL provide port rx_valid  input  1  one-cycle strobe; rx_data is valid when this is high.
REQ-006 SHALL provide port move_ack  input  1  one-cycle strobe from movement controller; the pending move has been taken.
REQ-007 SHALL provide port move_req  output  1  registered; high while a decoded move is pending.
REQ-008 SHALL provide port src_x, src_y, dst_x, dst_y  output  4 each  move squares; stable while move_req is high.
REQ-009 SHALL provide port capture  output  1  header bit[0] of the pending move.
REQ-010 SHALL provide port offset  output  1  header bit[1] of the pending move.
REQ-011 SHALL provide port scan_req, board_reset_req, game_over  output  1 each  one-cycle pulses.
REQ-012 SHALL provide port led_status  output  6  last status word received.
REQ-013 SHALL provide port protocol_error  output  1  one-cycle pulse on any rejected byte or timeout.

Function
REQ-014 SHALL decode the opcode from rx_data[7:6] of the first byte in state IDLE: 00 = control, 01 = move header, 10 = status, 11 = error.
REQ-015 SHALL decode the control codes as follows: 6'b000001 pulses scan_req, 6'b000010 pulses board_reset_req, 6'b000100 pulses game_over, and any other code pulses protocol_error; each pulse occurs the cycle after the rx_valid cycle.
REQ-016 SHALL load led_status with rx_data[5:0] on a status byte, one cycle latency, and hold it until the next status byte.
REQ-017 SHALL implement a state machine with states IDLE, GET_SRC and GET_DST.
REQ-018 SHALL, on an accepted move header, latch capture/offset from bits[1:0], ignore bits[5:2], and go IDLE -> GET_SRC.
REQ-019 SHALL treat every byte received in GET_SRC as the source square (x = [7:4], y = [3:0]) and go to GET_DST; opcode decoding is suppressed in that state.
REQ-020 SHALL treat every byte received in GET_DST as the destination square, assert move_req on the next cycle, and return to IDLE.
REQ-021 SHALL accept coordinates 0..9 only; a nibble greater than 9 in either operand byte aborts to IDLE, pulses protocol_error, and leaves move_req low.
REQ-022 SHALL hold move_req high until a move_ack is sampled, then clear it on the next edge; move_ack while move_req is low is ignored.
REQ-023 SHALL, while move_req is high, reject a new move header with a protocol_error pulse and stay in IDLE; control and status bytes are still processed.
REQ-024 SHALL treat move_ack and a move header in the same cycle as follows: the ack clears move_req and the header is accepted (IDLE -> GET_SRC).
REQ-025 SHALL keep outputs src/dst/capture/offset unchanged while a new sequence is being collected until move_req rises.
REQ-026 SHALL reload a 24-bit timeout counter to 0 on entering GET_SRC/GET_DST and on each accepted byte; the counter increments each cycle in those states.
REQ-027 SHALL, when the counter reaches TIMEOUT-1 without rx_valid, return to IDLE, pulse protocol_error, and leave move_req untouched.
REQ-028 SHALL, when rx_valid arrives on the same cycle as the timeout, accept the byte and apply no timeout.
REQ-029 SHALL ignore rx_data when rx_valid is low.

Reset
REQ-030 SHALL, on reset high (asynchronous, any state), force state IDLE, timeout counter 0, and all outputs 0 (move_req, src/dst, capture, offset, pulses, led_status = 6'b0).
REQ-031 SHALL discard a partially received move on reset mid-sequence; after release, the first byte is decoded as an opcode.

Verification
REQ-032 SHALL cover: bytes 8'h41, 8'h23, 8'h57 -> move_req=1 one cycle after the third byte, with src=(2,3), dst=(5,7), capture=1, offset=0; move_ack -> move_req=0 next cycle.
REQ-033 SHALL cover: bytes 8'h01, then 8'h02, then 8'h3F -> one scan_req pulse, one board_reset_req pulse, one protocol_error pulse; byte 8'h95 -> led_status=6'h15.
REQ-034 SHALL cover: while move_req is high, byte 8'h40 -> protocol_error pulse and state IDLE; the same byte together with move_ack -> accepted, state GET_SRC.
REQ-035 SHALL cover: bytes 8'h40, 8'hA2 -> protocol_error, state IDLE, move_req=0.
REQ-036 SHALL cover, with TIMEOUT=16: 8'h40, then no byte for 16 cycles -> protocol_error pulse and state IDLE; a following 8'h01 -> scan_req.
REQ-037 SHALL cover: reset asserted in GET_DST -> all outputs 0 immediately; after release, 8'h01 -> scan_req.

Source files
------------

// File: rtl/command_decoder.sv
// Host-link command decoder: single-byte control/status commands and
// three-byte move commands (header, source square, destination square).
module command_decoder #(
    parameter logic [23:0] TIMEOUT = 24'd1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       move_ack,
    output logic       move_req,
    output logic [3:0] src_x,
    output logic [3:0] src_y,
    output logic [3:0] dst_x,
    output logic [3:0] dst_y,
    output logic       capture,
    output logic       offset,
    output logic       scan_req,
    output logic       board_reset_req,
    output logic       game_over,
    output logic [5:0] led_status,
    output logic       protocol_error
);

    typedef enum logic [1:0] {IDLE, GET_SRC, GET_DST} state_t;

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic        move_req_q, move_req_d;
    logic [3:0]  src_x_q, src_x_d, src_y_q, src_y_d;
    logic [3:0]  dst_x_q, dst_x_d, dst_y_q, dst_y_d;
    logic        capture_q, capture_d, offset_q, offset_d;
    logic        scan_q, scan_d, brd_q, brd_d, over_q, over_d, err_q, err_d;
    logic [5:0]  led_q, led_d;
    // Shadow copies of the move being collected; published only when move_req rises.
    logic [3:0]  sh_sx_q, sh_sx_d, sh_sy_q, sh_sy_d;
    logic        sh_cap_q, sh_cap_d, sh_off_q, sh_off_d;

    logic hdr_accept;
    logic timeout_hit;
    logic coord_ok;

    assign hdr_accept  = (state_q == IDLE) && rx_valid && (rx_data[7:6] == 2'b01)
                         && (!move_req_q || move_ack);
    assign timeout_hit = (state_q != IDLE) && !rx_valid && (cnt_q == TIMEOUT - 24'd1);
    assign coord_ok    = (rx_data[7:4] <= 4'd9) && (rx_data[3:0] <= 4'd9);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (hdr_accept) state_d = GET_SRC;
            GET_SRC: begin
                if (rx_valid)         state_d = coord_ok ? GET_DST : IDLE;
                else if (timeout_hit) state_d = IDLE;
            end
            GET_DST: if (rx_valid || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        move_req_d = move_req_q;
        src_x_d    = src_x_q;
        src_y_d    = src_y_q;
        dst_x_d    = dst_x_q;
        dst_y_d    = dst_y_q;
        capture_d  = capture_q;
        offset_d   = offset_q;
        led_d      = led_q;
        sh_sx_d    = sh_sx_q;
        sh_sy_d    = sh_sy_q;
        sh_cap_d   = sh_cap_q;
        sh_off_d   = sh_off_q;
        scan_d     = 1'b0;
        brd_d      = 1'b0;
        over_d     = 1'b0;
        err_d      = 1'b0;

        if (state_d == IDLE)                  cnt_d = '0;
        else if (state_q == IDLE || rx_valid) cnt_d = '0;
        else                                  cnt_d = cnt_q + 24'd1;

        if (move_req_q && move_ack) move_req_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    unique case (rx_data[7:6])
                        2'b00: begin
                            unique case (rx_data[5:0])
                                6'b000001: scan_d = 1'b1;
                                6'b000010: brd_d  = 1'b1;
                                6'b000100: over_d = 1'b1;
                                default:   err_d  = 1'b1;
                            endcase
                        end
                        2'b01: begin
                            if (hdr_accept) begin
                                sh_cap_d = rx_data[0];
                                sh_off_d = rx_data[1];
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        2'b10:   led_d = rx_data[5:0];
                        default: err_d = 1'b1;
                    endcase
                end
            end
            GET_SRC: begin
                if (rx_valid) begin
                    if (coord_ok) begin
                        sh_sx_d = rx_data[7:4];
                        sh_sy_d = rx_data[3:0];
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (timeout_hit) begin
                    err_d = 1'b1;
                end
            end
            GET_DST: begin
                if (rx_valid) begin
                    if (coord_ok) begin
                        src_x_d    = sh_sx_q;
                        src_y_d    = sh_sy_q;
                        dst_x_d    = rx_data[7:4];
                        dst_y_d    = rx_data[3:0];
                        capture_d  = sh_cap_q;
                        offset_d   = sh_off_q;
                        move_req_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (timeout_hit) begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            move_req_q <= 1'b0;
            src_x_q    <= '0;
            src_y_q    <= '0;
            dst_x_q    <= '0;
            dst_y_q    <= '0;
            capture_q  <= 1'b0;
            offset_q   <= 1'b0;
            led_q      <= '0;
            sh_sx_q    <= '0;
            sh_sy_q    <= '0;
            sh_cap_q   <= 1'b0;
            sh_off_q   <= 1'b0;
            scan_q     <= 1'b0;
            brd_q      <= 1'b0;
            over_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            move_req_q <= move_req_d;
            src_x_q    <= src_x_d;
            src_y_q    <= src_y_d;
            dst_x_q    <= dst_x_d;
            dst_y_q    <= dst_y_d;
            capture_q  <= capture_d;
            offset_q   <= offset_d;
            led_q      <= led_d;
            sh_sx_q    <= sh_sx_d;
            sh_sy_q    <= sh_sy_d;
            sh_cap_q   <= sh_cap_d;
            sh_off_q   <= sh_off_d;
            scan_q     <= scan_d;
            brd_q      <= brd_d;
            over_q     <= over_d;
            err_q      <= err_d;
        end
    end

    assign move_req        = move_req_q;
    assign src_x           = src_x_q;
    assign src_y           = src_y_q;
    assign dst_x           = dst_x_q;
    assign dst_y           = dst_y_q;
    assign capture         = capture_q;
    assign offset          = offset_q;
    assign led_status      = led_q;
    assign scan_req        = scan_q;
    assign board_reset_req = brd_q;
    assign game_over       = over_q;
    assign protocol_error  = err_q;

endmodule

// File: tb/tb_command_decoder.sv
// Bench for command_decoder: directed scenarios plus a randomized byte stream,
// all checked against a message-level reference model.
module tb_command_decoder;

    localparam logic [23:0] TO = 24'd16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       move_ack;
    logic       move_req;
    logic [3:0] src_x, src_y, dst_x, dst_y;
    logic       capture, offset, scan_req, board_reset_req, game_over, protocol_error;
    logic [5:0] led_status;

    command_decoder #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .move_ack(move_ack), .move_req(move_req),
        .src_x(src_x), .src_y(src_y), .dst_x(dst_x), .dst_y(dst_y),
        .capture(capture), .offset(offset), .scan_req(scan_req),
        .board_reset_req(board_reset_req), .game_over(game_over),
        .led_status(led_status), .protocol_error(protocol_error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: a pending move, the bytes of the move being collected,
    // and the cycle index of the last accepted byte of that move.
    bit         m_req;
    logic [3:0] m_sx, m_sy, m_dx, m_dy;
    bit         m_cap, m_off;
    logic [5:0] m_led;
    bit         e_scan, e_brd, e_over, e_err;
    logic [7:0] m_seq[$];
    int         m_cyc, m_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_req = 0; m_sx = 0; m_sy = 0; m_dx = 0; m_dy = 0;
        m_cap = 0; m_off = 0; m_led = 0;
        e_scan = 0; e_brd = 0; e_over = 0; e_err = 0;
        m_seq.delete();
        m_last = 0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic ack);
        bit prev;
        logic [7:0] hdr, src;
        prev = m_req;
        e_scan = 0; e_brd = 0; e_over = 0; e_err = 0;
        if (ack && m_req) m_req = 0;
        if (m_seq.size() == 0) begin
            if (v) begin
                case (d[7:6])
                    2'd0: begin
                        if (d[5:0] == 6'd1)      e_scan = 1;
                        else if (d[5:0] == 6'd2) e_brd = 1;
                        else if (d[5:0] == 6'd4) e_over = 1;
                        else                     e_err = 1;
                    end
                    2'd1: begin
                        if (!prev || ack) begin
                            m_seq.push_back(d);
                            m_last = m_cyc;
                        end else begin
                            e_err = 1;
                        end
                    end
                    2'd2: m_led = d[5:0];
                    default: e_err = 1;
                endcase
            end
        end else if (v) begin
            if (d[7:4] > 4'd9 || d[3:0] > 4'd9) begin
                e_err = 1;
                m_seq.delete();
            end else if (m_seq.size() == 1) begin
                m_seq.push_back(d);
                m_last = m_cyc;
            end else begin
                hdr = m_seq[0];
                src = m_seq[1];
                m_cap = hdr[0]; m_off = hdr[1];
                m_sx = src[7:4]; m_sy = src[3:0];
                m_dx = d[7:4];   m_dy = d[3:0];
                m_req = 1;
                m_seq.delete();
            end
        end else if (m_cyc - m_last == int'(TO)) begin
            e_err = 1;
            m_seq.delete();
        end
    endtask

    task automatic compare_all(input string ctx);
        chk({ctx, "/move_req"}, 32'(move_req), 32'(m_req));
        chk({ctx, "/squares"}, 32'({src_x, src_y, dst_x, dst_y}), 32'({m_sx, m_sy, m_dx, m_dy}));
        chk({ctx, "/cap_off"}, 32'({capture, offset}), 32'({m_cap, m_off}));
        chk({ctx, "/led"}, 32'(led_status), 32'(m_led));
        chk({ctx, "/pulses"}, 32'({scan_req, board_reset_req, game_over, protocol_error}),
            32'({e_scan, e_brd, e_over, e_err}));
    endtask

    task automatic step(input string ctx, input logic v, input logic [7:0] d, input logic ack);
        rx_valid = v;
        rx_data  = d;
        move_ack = ack;
        @(posedge clk);
        m_cyc++;
        model_step(v, d, ack);
        #1;
        compare_all(ctx);
        rx_valid = 1'b0;
        move_ack = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic idle(input string ctx, input int n);
        for (int k = 0; k < n; k++) step(ctx, 1'b0, 8'($urandom), 1'b0);
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] b;
        case ($urandom % 8)
            0: begin
                b = 8'h01 << ($urandom % 3);
            end
            1: b = 8'($urandom);
            2, 3: b = 8'h40 | 8'($urandom % 4);
            4, 5: b = {4'($urandom % 10), 4'($urandom % 10)};
            6: b = {4'($urandom % 12), 4'($urandom % 12)};
            default: b = 8'h80 | 8'($urandom % 64);
        endcase
        return b;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_cyc = 0;
        model_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        move_ack = 1'b0;
        rx_data  = 8'h00;
        #1;
        compare_all("reset0");
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset1");
        reset = 1'b0;

        // Basic move, then acknowledge.
        step("m1_hdr", 1, 8'h41, 0);
        step("m1_src", 1, 8'h23, 0);
        step("m1_dst", 1, 8'h57, 0);
        chk("m1_req", 32'(move_req), 32'd1);
        chk("m1_sq", 32'({src_x, src_y, dst_x, dst_y}), 32'h2357);
        chk("m1_cap", 32'(capture), 32'd1);
        chk("m1_off", 32'(offset), 32'd0);
        idle("m1_hold", 3);
        step("m1_ack", 0, 8'h00, 1);
        chk("m1_ack_clr", 32'(move_req), 32'd0);

        // Control and status bytes.
        step("c_scan", 1, 8'h01, 0);
        chk("c_scan_p", 32'(scan_req), 32'd1);
        step("c_brd", 1, 8'h02, 0);
        chk("c_brd_p", 32'(board_reset_req), 32'd1);
        step("c_bad", 1, 8'h3F, 0);
        chk("c_bad_p", 32'(protocol_error), 32'd1);
        step("c_over", 1, 8'h04, 0);
        step("c_stat", 1, 8'h95, 0);
        chk("c_led", 32'(led_status), 32'h15);
        step("c_errop", 1, 8'hC0, 0);

        // Header while a move is pending, then header with ack.
        step("p_hdr", 1, 8'h41, 0);
        step("p_src", 1, 8'h23, 0);
        step("p_dst", 1, 8'h57, 0);
        step("p_rej", 1, 8'h40, 0);
        chk("p_rej_err", 32'(protocol_error), 32'd1);
        step("p_idle", 1, 8'h01, 0);
        chk("p_idle_scan", 32'(scan_req), 32'd1);
        step("p_acc", 1, 8'h40, 1);
        chk("p_acc_req", 32'(move_req), 32'd0);
        chk("p_acc_keep", 32'({src_x, src_y, dst_x, dst_y}), 32'h2357);
        step("p_src2", 1, 8'h01, 0);
        step("p_dst2", 1, 8'h99, 0);
        chk("p_sq2", 32'({src_x, src_y, dst_x, dst_y}), 32'h0199);
        step("p_ack2", 0, 8'h00, 1);

        // Out-of-range coordinate.
        step("r_hdr", 1, 8'h40, 0);
        step("r_bad", 1, 8'hA2, 0);
        chk("r_err", 32'(protocol_error), 32'd1);
        chk("r_req", 32'(move_req), 32'd0);
        step("r_hdr2", 1, 8'h43, 0);
        step("r_src2", 1, 8'h12, 0);
        step("r_bad2", 1, 8'h3B, 0);
        chk("r_err2", 32'(protocol_error), 32'd1);

        // Timeout, and a byte landing exactly on the timeout cycle.
        step("t_hdr", 1, 8'h40, 0);
        idle("t_wait", 15);
        step("t_fire", 0, 8'h00, 0);
        chk("t_err", 32'(protocol_error), 32'd1);
        step("t_scan", 1, 8'h01, 0);
        chk("t_scan_p", 32'(scan_req), 32'd1);
        step("t2_hdr", 1, 8'h42, 0);
        idle("t2_wait", 15);
        step("t2_src", 1, 8'h34, 0);
        chk("t2_noerr", 32'(protocol_error), 32'd0);
        idle("t2_wait2", 15);
        step("t2_dst", 1, 8'h56, 0);
        chk("t2_req", 32'(move_req), 32'd1);
        chk("t2_off", 32'(offset), 32'd1);

        // Reset in the middle of a move.
        step("x_hdr", 1, 8'h41, 1);
        step("x_src", 1, 8'h23, 0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all("x_rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("x_scan", 1, 8'h01, 0);
        chk("x_scan_p", 32'(scan_req), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom % 25 == 0) begin
                idle("rnd_gap", 14 + int'($urandom % 5));
            end else begin
                step("rnd", 1'($urandom % 2 == 0), rand_byte(), 1'($urandom % 4 == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
